// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard_pkg
// Brief    : Shared constants for the pipeline hazard/forwarding scoreboard.
// Revision : 1.0
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int c_FWD_SEL_RF = 0;
    localparam int c_SB_RDY_EX  = 1;
    localparam int c_SB_RDY_DM  = 2;
    localparam int c_SEL_BIT    = 3;
    localparam int c_RDY_BIT    = 2;

endpackage
`default_nettype wire

// File: rtl/hazard_src_match.sv
`default_nettype none
// ============================================================================
// Module   : hazard_src_match
// Brief    : Priority match of one source operand against in-flight writers.
// Revision : 1.0
// ============================================================================
module hazard_src_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int DEPTH            = 3,
    parameter int REQ_BIT          = 5,
    parameter int RDY_BIT          = c_RDY_BIT,
    parameter int SEL_BIT          = c_SEL_BIT,
    parameter int RF_WRITE_THROUGH = 0
) (
    input  logic                            i_active,
    input  logic [REQ_BIT-1:0]              i_src,
    input  logic [DEPTH-1:0]                i_valid,
    input  logic [DEPTH-1:0]                i_wen,
    input  logic [DEPTH-1:0][REQ_BIT-1:0]   i_dst,
    input  logic [DEPTH-1:0][RDY_BIT-1:0]   i_rdy,
    output logic                            o_hazard,
    output logic [SEL_BIT-1:0]              o_sel
);

    logic w_hit;
    int   w_match_k;
    int   w_match_rdy;

    always_comb begin
        w_hit       = 1'b0;
        w_match_k   = 0;
        w_match_rdy = 0;
        // Scan oldest to youngest so the youngest writer overwrites the result.
        for (int k = DEPTH; k >= 1; k--) begin
            if (i_valid[k-1] && i_wen[k-1] && (i_dst[k-1] == i_src)) begin
                w_hit       = 1'b1;
                w_match_k   = k;
                w_match_rdy = int'(i_rdy[k-1]);
            end
        end

        o_hazard = 1'b0;
        o_sel    = SEL_BIT'(c_FWD_SEL_RF);
        if (i_active && w_hit) begin
            if (w_match_k < w_match_rdy) begin
                o_hazard = 1'b1;
            end else if (w_match_k == DEPTH) begin
                o_sel = (RF_WRITE_THROUGH != 0) ? SEL_BIT'(c_FWD_SEL_RF) : SEL_BIT'(DEPTH + 1);
            end else begin
                o_sel = SEL_BIT'(w_match_k + 1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : hazard_scoreboard
// Brief    : In-order pipeline hazard unit: bypass selects, load-use stall,
//            redirect kill and saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NUM_SRC          = 2,
    parameter int DEPTH            = 3,
    parameter int REQ_BIT          = 5,
    parameter int RDY_BIT          = c_RDY_BIT,
    parameter int SEL_BIT          = c_SEL_BIT,
    parameter int RF_WRITE_THROUGH = 0,
    parameter int CNT_BIT          = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       id_valid,
    input  logic [NUM_SRC*REQ_BIT-1:0] id_src_req,
    input  logic [NUM_SRC-1:0]         id_src_used,
    input  logic [REQ_BIT-1:0]         id_dst_req,
    input  logic                       id_dst_wen,
    input  logic [RDY_BIT-1:0]         id_rdy_stage,
    input  logic                       redirect,
    output logic                       stall,
    output logic [NUM_SRC*SEL_BIT-1:0] fwd_sel,
    output logic [CNT_BIT-1:0]         stall_cnt,
    output logic [CNT_BIT-1:0]         flush_cnt
);

    // Index 0 holds stage 1 (EX), index DEPTH-1 holds the oldest stage.
    logic [DEPTH-1:0]               r_valid_q, r_valid_d;
    logic [DEPTH-1:0]               r_wen_q,   r_wen_d;
    logic [DEPTH-1:0][REQ_BIT-1:0]  r_dst_q,   r_dst_d;
    logic [DEPTH-1:0][RDY_BIT-1:0]  r_rdy_q,   r_rdy_d;
    logic [CNT_BIT-1:0]             r_stall_cnt_q, r_stall_cnt_d;
    logic [CNT_BIT-1:0]             r_flush_cnt_q, r_flush_cnt_d;
    logic [NUM_SRC-1:0]             w_hazard;

    generate
        for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
            logic w_active;
            assign w_active = id_valid && id_src_used[s] &&
                              (id_src_req[s*REQ_BIT +: REQ_BIT] != '0);

            hazard_src_match #(
                .DEPTH            (DEPTH),
                .REQ_BIT          (REQ_BIT),
                .RDY_BIT          (RDY_BIT),
                .SEL_BIT          (SEL_BIT),
                .RF_WRITE_THROUGH (RF_WRITE_THROUGH)
            ) u_match (
                .i_active (w_active),
                .i_src    (id_src_req[s*REQ_BIT +: REQ_BIT]),
                .i_valid  (r_valid_q),
                .i_wen    (r_wen_q),
                .i_dst    (r_dst_q),
                .i_rdy    (r_rdy_q),
                .o_hazard (w_hazard[s]),
                .o_sel    (fwd_sel[s*SEL_BIT +: SEL_BIT])
            );
        end
    endgenerate

    // A taken redirect kills the ID instruction, so its hazards are moot.
    assign stall     = (|w_hazard) && !redirect;
    assign stall_cnt = r_stall_cnt_q;
    assign flush_cnt = r_flush_cnt_q;

    always_comb begin
        r_valid_d     = r_valid_q;
        r_wen_d       = r_wen_q;
        r_dst_d       = r_dst_q;
        r_rdy_d       = r_rdy_q;
        r_stall_cnt_d = r_stall_cnt_q;
        r_flush_cnt_d = r_flush_cnt_q;
        if (en) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                r_valid_d[k] = r_valid_q[k-1];
                r_wen_d[k]   = r_wen_q[k-1];
                r_dst_d[k]   = r_dst_q[k-1];
                r_rdy_d[k]   = r_rdy_q[k-1];
            end
            if (id_valid && !stall && !redirect) begin
                r_valid_d[0] = 1'b1;
                r_wen_d[0]   = id_dst_wen && (id_dst_req != '0);
                r_dst_d[0]   = id_dst_req;
                r_rdy_d[0]   = id_rdy_stage;
            end else begin
                r_valid_d[0] = 1'b0;
                r_wen_d[0]   = 1'b0;
                r_dst_d[0]   = '0;
                r_rdy_d[0]   = '0;
            end
            if (stall && !(&r_stall_cnt_q)) begin
                r_stall_cnt_d = r_stall_cnt_q + CNT_BIT'(1);
            end
            if (redirect && !(&r_flush_cnt_q)) begin
                r_flush_cnt_d = r_flush_cnt_q + CNT_BIT'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_q     <= '0;
            r_wen_q       <= '0;
            r_dst_q       <= '0;
            r_rdy_q       <= '0;
            r_stall_cnt_q <= '0;
            r_flush_cnt_q <= '0;
        end else begin
            r_valid_q     <= r_valid_d;
            r_wen_q       <= r_wen_d;
            r_dst_q       <= r_dst_d;
            r_rdy_q       <= r_rdy_d;
            r_stall_cnt_q <= r_stall_cnt_d;
            r_flush_cnt_q <= r_flush_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding unit for the in-order CPU pipeline.
- Keeps a shadow of in-flight writers: destination register, write enable and result-ready stage, one entry per post-ID stage.
- Driven from ID; the forwarding selects it produces are registered into ID/EX and consumed in EX.
- Generates per-operand bypass selects, the load-use stall (which closes the IF/ID stall TODO) and flush bookkeeping with performance counters.

Parameters:
- NUM_SRC, 2, number of source operands checked per instruction.
- DEPTH, 3, tracked post-ID stages; 1=EX, 2=DM, 3=WB.
- REQ_BIT, 5, register index width.
- RDY_BIT, 2, width of the result-ready stage field.
- SEL_BIT, 3, forwarding-select width; must hold values 0..DEPTH+1.
- RF_WRITE_THROUGH, 0, 1 means the regfile forwards same-cycle writes, so tap DEPTH+1 is never selected.
- CNT_BIT, 32, performance counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  global enable; 0 freezes all state
- id_valid  in  1  ID holds a real instruction
- id_src_req  in  NUM_SRC*REQ_BIT  source register indices, operand 0 in the LSBs
- id_src_used  in  NUM_SRC  per-operand "actually read" flag
- id_dst_req  in  REQ_BIT  destination register
- id_dst_wen  in  1  instruction writes the regfile
- id_rdy_stage  in  RDY_BIT  stage after which the result exists (ALU=1, load=2)
- redirect  in  1  jump/branch taken in EX this cycle
- stall  out  1  hold PC and IF/ID, insert bubble into ID/EX
- fwd_sel  out  NUM_SRC*SEL_BIT  per-operand tap: 0=regfile, j=value carried into stage j, DEPTH+1=retired-write holding register
- stall_cnt  out  CNT_BIT  cycles stalled
- flush_cnt  out  CNT_BIT  redirects taken

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on rst_n.
- Reset values: all entries invalid, stall_cnt=0, flush_cnt=0. With entries invalid, stall=0 and fwd_sel=0 follow combinationally.
- Entry k (1..DEPTH) is the instruction currently in stage k, with fields {valid, wen, dst, rdy}.
- Source match, per operand s:
  - Active only when id_valid && id_src_used[s] && src!=0.
  - Find the smallest k with valid && wen && dst==src; the youngest writer wins.
  - No match: fwd_sel=0.
  - Match and k>=rdy: fwd_sel=k+1, the tap the producer occupies when the consumer reaches EX.
  - Match and k<rdy: hazard on s.
  - Match at k=DEPTH: fwd_sel=DEPTH+1, or 0 if RF_WRITE_THROUGH=1.
- Stall: stall = (OR of per-operand hazards) && !redirect. Purely combinational, zero latency; fwd_sel is don't-care while stall=1.
- Update on the clk edge when en=1:
  - Entries k=2..DEPTH take entry k-1; entry DEPTH retires.
  - Entry 1 takes the ID instruction when id_valid && !stall && !redirect.
  - Otherwise entry 1 takes a bubble (valid=0).
  - Entries with id_dst_wen=1 and id_dst_req=0 are stored with wen=0.
- Counters:
  - stall_cnt increments when stall=1; flush_cnt increments when redirect=1.
  - Both saturate at all-ones and never wrap.
- en=0: no shift, no counter change; outputs still evaluate combinationally.
- Simultaneous redirect and hazard: redirect wins. Stall=0, the ID instruction is killed (bubble), flush_cnt+1, stall_cnt unchanged.
- A stall lasts at most max(rdy)-1 cycles per producer; with the ALU/load mix the maximum is 1 cycle.
- Reset mid-operation: all entries are dropped immediately, even with a stall pending.

Decomposition:
- Add to Core.vh: FWD_SEL_RF=0, SB_RDY_EX=1, SB_RDY_DM=2, and the SEL_BIT/RDY_BIT widths.
- Sub-module hazard_src_match: combinational priority match of one operand against the DEPTH entries; outputs {hazard, sel}. Instantiated NUM_SRC times by generate.

Test Plan:
1. addu $1 (rdy=1), then addu $2,$1,$1 next cycle -> stall=0, fwd_sel[0]=fwd_sel[1]=2.
2. lw $3 (rdy=2), then addu using $3 -> stall=1 for exactly 1 cycle, stall_cnt=1; next cycle fwd_sel=3.
3. ALU write $4, then two independent instructions, then a use of $4 -> producer at k=3, fwd_sel=4. Repeat with RF_WRITE_THROUGH=1 -> fwd_sel=0.
4. Two in-flight writers of $5 (k=1 ALU, k=2 load), consumer of $5 -> fwd_sel=2 (youngest wins), no stall.
5. Write to $0, then a use of $0 -> stall=0, fwd_sel=0.
6. Load-use hazard and redirect=1 in the same cycle -> stall=0, entry 1 bubble, flush_cnt=1, stall_cnt=0.
7. en=0 for 3 cycles mid-stall -> entries and counters frozen, stall stays 1.
8. rst_n low mid-stall -> stall=0 asynchronously and both counters read 0.
